xorshift32_rr_server: RTL and testbench

Round-robin server that shares one xorshift32 generator among `NUM_REQ` consumers. It sits between the RNG datapath and the stochastic compute lanes. The generator state advances only when a random word is handed out, so every draw is unique and the global draw order is deterministic. The block also sequences reseeding with zero-seed protection and a post-seed warm-up discard.

---
 rtl/rng_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/xorshift32_rr_server.sv | 113 +++++++++++
 tb/tb_xorshift32_rr_server.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared xorshift32 definitions: shift amounts, default seed, next-state function
// and the server FSM state encoding.
package rng_pkg;

  // xorshift32 triple: left 13, right 17, left 5 (logical shifts, 32-bit truncation)
  localparam int XS_SHL_A = 13;
  localparam int XS_SHR_B = 17;
  localparam int XS_SHL_C = 5;

  localparam logic [31:0] DEFAULT_SEED = 32'h2545F491;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } srv_state_t;

  function automatic logic [31:0] xs32_next(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << XS_SHL_A);
    t = t ^ (t >> XS_SHR_B);
    t = t ^ (t << XS_SHL_C);
    return t;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps upward;
// it produces a one-hot grant, the granted index and an any-grant flag.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [NUM_REQ-1:0] req_masked;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign req_masked[gi] = req[gi] & en;
    end
  endgenerate

  always_comb begin
    int cand;
    cand = 0;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any && req_masked[IW'(cand)]) begin
        any = 1'b1;
        gnt[IW'(cand)] = 1'b1;
        idx = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/xorshift32_rr_server.sv
// Shares one xorshift32 generator among NUM_REQ consumers; the state advances only
// on a handed-out draw, with reseed sequencing, zero-seed substitution and warm-up.
module xorshift32_rr_server #(
  parameter int          NUM_REQ      = 4,
  parameter int          WARMUP       = 4,
  parameter logic [31:0] DEFAULT_SEED = rng_pkg::DEFAULT_SEED
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                seed,
  input  logic                       re_seed,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [31:0]                rsp_data,
  output logic                       warming,
  output logic                       zero_seed_err,
  output logic [31:0]                draw_count
);
  import rng_pkg::*;

  localparam int         IW        = $clog2(NUM_REQ);
  localparam logic [7:0] WARMUP_W  = 8'(WARMUP);
  localparam srv_state_t INIT_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  srv_state_t     state_reg;
  logic [31:0]    s_reg;
  logic [7:0]     wcnt_reg;
  logic [IW-1:0]  ptr_reg;
  logic           rsp_valid_reg;
  logic [IW-1:0]  rsp_id_reg;
  logic [31:0]    rsp_data_reg;
  logic           zero_seed_err_reg;
  logic [31:0]    draw_count_reg;

  logic           arb_en;
  logic [IW-1:0]  gnt_idx;
  logic           gnt_any;
  logic [31:0]    s_next;
  logic [IW-1:0]  ptr_next;

  // A reseed strobe (or reset) suppresses the grant so the state never loads and advances together
  assign arb_en = (state_reg == ST_RUN) && !re_seed && !rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req (req),
    .ptr (ptr_reg),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign s_next   = xs32_next(s_reg);
  assign ptr_next = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= INIT_STATE;
      s_reg             <= DEFAULT_SEED;
      wcnt_reg          <= WARMUP_W;
      ptr_reg           <= '0;
      rsp_valid_reg     <= 1'b0;
      rsp_id_reg        <= '0;
      rsp_data_reg      <= '0;
      zero_seed_err_reg <= 1'b0;
      draw_count_reg    <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      if (re_seed) begin
        if (seed == 32'd0) begin
          s_reg             <= DEFAULT_SEED;
          zero_seed_err_reg <= 1'b1;
        end else begin
          s_reg <= seed;
        end
        wcnt_reg  <= WARMUP_W;
        state_reg <= INIT_STATE;
      end else begin
        case (state_reg)
          ST_WARMUP: begin
            s_reg    <= s_next;
            wcnt_reg <= wcnt_reg - 8'd1;
            if (wcnt_reg <= 8'd1) state_reg <= ST_RUN;
          end
          ST_RUN: begin
            if (gnt_any) begin
              s_reg          <= s_next;
              ptr_reg        <= ptr_next;
              draw_count_reg <= draw_count_reg + 32'd1;
              rsp_valid_reg  <= 1'b1;
              rsp_id_reg     <= gnt_idx;
              rsp_data_reg   <= s_reg;
            end
          end
          default: state_reg <= INIT_STATE;
        endcase
      end
    end
  end

  assign rsp_valid     = rsp_valid_reg;
  assign rsp_id        = rsp_id_reg;
  assign rsp_data      = rsp_data_reg;
  assign warming       = (state_reg == ST_WARMUP);
  assign zero_seed_err = zero_seed_err_reg;
  assign draw_count    = draw_count_reg;

endmodule

// File: tb/tb_xorshift32_rr_server.sv
// Self-checking bench: table-driven vectors on a WARMUP=0 instance with a response
// scoreboard, plus a hand-written warm-up sequence on a WARMUP=2 instance.
module tb_xorshift32_rr_server;

  localparam logic [31:0] DSEED = 32'h2545F491;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // WARMUP=0 instance
  logic        rst, re_seed;
  logic [31:0] seed;
  logic [3:0]  req, gnt;
  logic        rsp_valid, warming, zero_seed_err;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data, draw_count;

  // WARMUP=2 instance
  logic        w_rst, w_re_seed;
  logic [31:0] w_seed;
  logic [3:0]  w_req, w_gnt;
  logic        w_rsp_valid, w_warming, w_zero_seed_err;
  logic [1:0]  w_rsp_id;
  logic [31:0] w_rsp_data, w_draw_count;

  xorshift32_rr_server #(.NUM_REQ(4), .WARMUP(0), .DEFAULT_SEED(DSEED)) dut (
    .clk(clk), .rst(rst), .seed(seed), .re_seed(re_seed), .req(req), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .warming(warming),
    .zero_seed_err(zero_seed_err), .draw_count(draw_count)
  );

  xorshift32_rr_server #(.NUM_REQ(4), .WARMUP(2), .DEFAULT_SEED(DSEED)) dut_w (
    .clk(clk), .rst(w_rst), .seed(w_seed), .re_seed(w_re_seed), .req(w_req), .gnt(w_gnt),
    .rsp_valid(w_rsp_valid), .rsp_id(w_rsp_id), .rsp_data(w_rsp_data), .warming(w_warming),
    .zero_seed_err(w_zero_seed_err), .draw_count(w_draw_count)
  );

  typedef struct {
    logic        rst;
    logic        re_seed;
    logic [31:0] seed;
    logic [3:0]  req;
    logic [3:0]  exp_gnt;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  localparam int NV = 25;
  vec_t vecs [NV];
  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_s, m_draw;
  logic        m_err;

  function automatic logic [31:0] ref_xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ {y[18:0], 13'd0};
    y = y ^ {17'd0, y[31:17]};
    y = y ^ {y[26:0], 5'd0};
    return y;
  endfunction

  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < 4; k++) if (oh[k]) r = 2'(k);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic r, input logic rs, input logic [31:0] sd,
                      input logic [3:0] rq, input logic [3:0] g);
    vecs[i] = '{rst: r, re_seed: rs, seed: sd, req: rq, exp_gnt: g};
  endtask

  task automatic check_rsp();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_data", rsp_data, e.data);
      $display("rsp id=%0d data=%h", rsp_id, rsp_data);
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'd0);
    end
    chk("draw_count", draw_count, m_draw);
    chk("zero_seed_err", 32'(zero_seed_err), 32'(m_err));
    chk("warming0", 32'(warming), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w_exp;
    int n;

    setv( 0, 0, 0, 32'd0,        4'b0000, 4'b0000);
    setv( 1, 0, 1, 32'd1,        4'b0001, 4'b0000);
    setv( 2, 0, 0, 32'd0,        4'b0001, 4'b0001);
    setv( 3, 0, 0, 32'd0,        4'b0001, 4'b0001);
    setv( 4, 0, 0, 32'd0,        4'b0001, 4'b0001);
    setv( 5, 1, 0, 32'd0,        4'b0001, 4'b0000);
    setv( 6, 0, 1, 32'd1,        4'b1111, 4'b0000);
    setv( 7, 0, 0, 32'd0,        4'b1111, 4'b0001);
    setv( 8, 0, 0, 32'd0,        4'b1111, 4'b0010);
    setv( 9, 0, 0, 32'd0,        4'b1111, 4'b0100);
    setv(10, 0, 0, 32'd0,        4'b1111, 4'b1000);
    setv(11, 0, 0, 32'd0,        4'b1010, 4'b0010);
    setv(12, 0, 0, 32'd0,        4'b1011, 4'b1000);
    setv(13, 0, 0, 32'd0,        4'b0110, 4'b0010);
    setv(14, 0, 1, 32'd0,        4'b0100, 4'b0000);
    setv(15, 0, 0, 32'd0,        4'b0100, 4'b0100);
    setv(16, 0, 1, 32'hDEADBEEF, 4'b0010, 4'b0000);
    setv(17, 0, 0, 32'd0,        4'b0010, 4'b0010);
    setv(18, 0, 0, 32'd0,        4'b0000, 4'b0000);
    setv(19, 0, 0, 32'd0,        4'b1001, 4'b1000);
    setv(20, 0, 0, 32'd0,        4'b0001, 4'b0001);
    setv(21, 1, 0, 32'd0,        4'b1111, 4'b0000);
    setv(22, 0, 0, 32'd0,        4'b1111, 4'b0001);
    setv(23, 0, 0, 32'd0,        4'b0011, 4'b0010);
    setv(24, 0, 0, 32'd0,        4'b0000, 4'b0000);

    rst = 1'b1; re_seed = 1'b0; seed = '0; req = '0;
    w_rst = 1'b1; w_re_seed = 1'b0; w_seed = '0; w_req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state of both instances
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_draw_count", draw_count, 32'd0);
    chk("rst_zero_seed_err", 32'(zero_seed_err), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_warming0", 32'(warming), 32'd0);
    chk("rst_w_warming", 32'(w_warming), 32'd1);
    chk("rst_w_gnt", 32'(w_gnt), 32'd0);

    m_s = DSEED; m_draw = 32'd0; m_err = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      check_rsp();
      rst     = vecs[i].rst;
      re_seed = vecs[i].re_seed;
      seed    = vecs[i].seed;
      req     = vecs[i].req;
      #1;
      chk($sformatf("gnt[%0d]", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      $display("vec %0d rst=%b re_seed=%b seed=%h req=%b gnt=%b", i, rst, re_seed, seed, req, gnt);
      if (vecs[i].rst) begin
        m_s = DSEED; m_draw = 32'd0; m_err = 1'b0;
      end else if (vecs[i].re_seed) begin
        m_s = (vecs[i].seed == 32'd0) ? DSEED : vecs[i].seed;
        if (vecs[i].seed == 32'd0) m_err = 1'b1;
      end else if (vecs[i].exp_gnt != 4'b0000) begin
        sb.push_back('{id: oh_idx(vecs[i].exp_gnt), data: m_s});
        m_s = ref_xs(m_s);
        m_draw = m_draw + 32'd1;
      end
      @(negedge clk);
    end
    check_rsp();
    rst = 1'b0; re_seed = 1'b0; req = '0;

    // WARMUP=2: two silent warm-up cycles after reset, then a grant
    w_rst = 1'b0;
    w_req = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("w_rst_warm_gnt", 32'(w_gnt), 32'd0);
      chk("w_rst_warming", 32'(w_warming), 32'd1);
      @(negedge clk);
    end
    #1;
    chk("w_first_gnt", 32'(w_gnt), 32'b0001);
    chk("w_warming_off", 32'(w_warming), 32'd0);
    w_exp = ref_xs(ref_xs(DSEED));
    @(negedge clk);
    chk("w_first_valid", 32'(w_rsp_valid), 32'd1);
    chk("w_first_data", w_rsp_data, w_exp);
    $display("w rsp id=%0d data=%h", w_rsp_id, w_rsp_data);

    // Reseed 1 with req held: warm-up discards 1 and 0x42021
    w_re_seed = 1'b1;
    w_seed = 32'd1;
    #1;
    chk("w_reseed_gnt", 32'(w_gnt), 32'd0);
    @(negedge clk);
    w_re_seed = 1'b0;
    #1;
    n = 0;
    while (w_gnt == 4'b0000 && n < 10) begin
      chk("w_warming_during", 32'(w_warming), 32'd1);
      @(negedge clk);
      #1;
      n++;
    end
    chk("w_warm_len", 32'(n), 32'd2);
    @(negedge clk);
    chk("w_seeded_valid", 32'(w_rsp_valid), 32'd1);
    chk("w_seeded_data", w_rsp_data, 32'h04080601);
    chk("w_draw_count", w_draw_count, 32'd2);
    $display("w rsp id=%0d data=%h", w_rsp_id, w_rsp_data);
    w_req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
